// File: rtl/cdc_handshake_tx_if.sv
// Bundle for the cdc_handshake_tx local valid/ready stream and the cross-domain req/ack bus.
// master: the transmitter block. slave: the local producer plus the remote receiver.
interface cdc_handshake_tx_if #(
   parameter int unsigned Width = 32
) ();

   logic             in_valid;
   logic             in_ready;
   logic [Width-1:0] in_data;
   logic             xfer_req;
   logic [Width-1:0] xfer_data;
   logic             xfer_ack;
   logic             xfer_done;
   logic             timeout_err;

   modport master (
      input  in_valid,
      input  in_data,
      input  xfer_ack,
      output in_ready,
      output xfer_req,
      output xfer_data,
      output xfer_done,
      output timeout_err
   );

   modport slave (
      output in_valid,
      output in_data,
      output xfer_ack,
      input  in_ready,
      input  xfer_req,
      input  xfer_data,
      input  xfer_done,
      input  timeout_err
   );

endinterface

// File: rtl/cdc_handshake_tx.sv
// Source side of a 4-phase req/ack CDC handshake: captures a word, holds it, and runs req/ack.
// Optional watchdog on the acknowledge wait is built when CDC_TX_TIMEOUT_EN is defined.
module cdc_handshake_tx #(
   parameter int unsigned Width         = 32,
   parameter int unsigned SyncDepth     = 2,
   parameter int unsigned TimeoutCycles = 1024
) (
   input logic                clk,
   input logic                rst,
   cdc_handshake_tx_if.master bus
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SETUP    = 2'd1,
      REQ_HIGH = 2'd2,
      REQ_LOW  = 2'd3
   } state_e;

   if (SyncDepth < 2) begin : g_bad_sync_depth
      $error("cdc_handshake_tx: SyncDepth must be at least 2");
   end
   if (TimeoutCycles < 2) begin : g_bad_timeout
      $error("cdc_handshake_tx: TimeoutCycles must be at least 2");
   end

   state_e               state_q, state_d;
   logic [SyncDepth-1:0] sync_q, sync_d;
   logic                 ack_s;
   logic                 xfer_req_q, xfer_req_d;
   logic [Width-1:0]     xfer_data_q, xfer_data_d;
   logic                 xfer_done_q, xfer_done_d;

   // Acknowledge synchronizer; only the last stage is ever looked at.
   assign ack_s  = sync_q[SyncDepth-1];
   assign sync_d = {sync_q[SyncDepth-2:0], bus.xfer_ack};

   always_comb begin
      state_d     = state_q;
      xfer_req_d  = xfer_req_q;
      xfer_data_d = xfer_data_q;
      xfer_done_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.in_valid && !ack_s) begin
               xfer_data_d = bus.in_data;
               state_d     = SETUP;
            end
         end
         SETUP: begin
            xfer_req_d = 1'b1;
            state_d    = REQ_HIGH;
         end
         REQ_HIGH: begin
            if (ack_s) begin
               xfer_req_d = 1'b0;
               state_d    = REQ_LOW;
            end
         end
         REQ_LOW: begin
            if (!ack_s) begin
               xfer_done_d = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         sync_q      <= '0;
         xfer_req_q  <= 1'b0;
         xfer_data_q <= '0;
         xfer_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync_q      <= sync_d;
         xfer_req_q  <= xfer_req_d;
         xfer_data_q <= xfer_data_d;
         xfer_done_q <= xfer_done_d;
      end
   end

   // A stale acknowledge left over from an interrupted transfer blocks new captures.
   assign bus.in_ready  = (state_q == IDLE) && !ack_s;
   assign bus.xfer_req  = xfer_req_q;
   assign bus.xfer_data = xfer_data_q;
   assign bus.xfer_done = xfer_done_q;

`ifdef CDC_TX_TIMEOUT_EN
   localparam int unsigned CntW   = $clog2(TimeoutCycles) + 1;
   localparam int unsigned CntMax = TimeoutCycles - 1;

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            timeout_err_q, timeout_err_d;
   logic            waiting;
   logic            entering;

   assign waiting  = (state_q == REQ_HIGH) || (state_q == REQ_LOW);
   assign entering = (state_d != state_q) &&
                     ((state_d == REQ_HIGH) || (state_d == REQ_LOW));

   // Counter saturates at the limit so a very long wait cannot wrap it.
   always_comb begin
      cnt_d         = cnt_q;
      timeout_err_d = timeout_err_q;
      if (entering) begin
         cnt_d = '0;
      end else if (waiting && (cnt_q != CntW'(CntMax))) begin
         cnt_d = cnt_q + CntW'(1);
      end
      if (waiting && (cnt_q == CntW'(CntMax))) begin
         timeout_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q         <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign bus.timeout_err = timeout_err_q;
`else
   assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed bench for cdc_handshake_tx (Width=32, SyncDepth=2); timeout scenario follows CDC_TX_TIMEOUT_EN.
module tb_cdc_handshake_tx;

`ifdef CDC_TX_TIMEOUT_EN
   localparam int unsigned TO    = 16;
   localparam bit          TO_ON = 1'b1;
`else
   localparam int unsigned TO    = 1024;
   localparam bit          TO_ON = 1'b0;
`endif

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   cdc_handshake_tx_if #(.Width(32)) bus ();

   cdc_handshake_tx #(
      .Width        (32),
      .SyncDepth    (2),
      .TimeoutCycles(TO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req(input logic lvl, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (bus.xfer_req === lvl) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (bus.xfer_done === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.xfer_ack = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      n_checks++;
      if (bus.xfer_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", bus.xfer_req); end
      n_checks++;
      if (bus.xfer_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 00000000", bus.xfer_data); end
      n_checks++;
      if (bus.xfer_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.xfer_done); end
      n_checks++;
      if (bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", bus.timeout_err); end
      tick();
      tick();
      n_checks++;
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", bus.in_ready); end
   endtask

   task automatic test_basic();
      bus.in_valid = 1'b1;
      bus.in_data  = 32'hDEADBEEF;
      tick();  // capture edge
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      n_checks++;
      if (bus.xfer_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL basic_capture: got %h expected deadbeef", bus.xfer_data); end
      n_checks++;
      if (bus.xfer_req !== 1'b0) begin n_fail++; $display("FAIL basic_setup_req: got %b expected 0", bus.xfer_req); end
      n_checks++;
      if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_setup_ready: got %b expected 0", bus.in_ready); end
      tick();
      n_checks++;
      if (bus.xfer_req !== 1'b1) begin n_fail++; $display("FAIL basic_req_rise: got %b expected 1", bus.xfer_req); end
      tick();
      bus.xfer_ack = 1'b1;
      // Ack passes two sync stages, then the FSM reacts on the third edge.
      for (int k = 1; k <= 3; k++) begin
         tick();
         n_checks++;
         if (bus.xfer_req !== logic'(k < 3)) begin
            n_fail++; $display("FAIL basic_req_fall edge%0d: got %b expected %b", k, bus.xfer_req, (k < 3));
         end
      end
      tick();
      bus.xfer_ack = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         tick();
         n_checks++;
         if (bus.xfer_done !== logic'(k == 3)) begin
            n_fail++; $display("FAIL basic_done edge%0d: got %b expected %b", k, bus.xfer_done, (k == 3));
         end
         if (k >= 2 && k <= 3) begin
            n_checks++;
            if (bus.in_ready !== logic'(k == 3)) begin
               n_fail++; $display("FAIL basic_ready edge%0d: got %b expected %b", k, bus.in_ready, (k == 3));
            end
         end
      end
      n_checks++;
      if (bus.xfer_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL basic_retain: got %h expected deadbeef", bus.xfer_data); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] words [3];
      logic [31:0] held;
      int          acc;
      int          nreq;
      int          ndone;
      logic        req_prev;
      logic        busy;
      logic        will_accept;
      words[0] = 32'h1;
      words[1] = 32'h2;
      words[2] = 32'h3;
      acc = 0; nreq = 0; ndone = 0;
      req_prev = 1'b0; busy = 1'b0; held = '0;
      bus.in_valid = 1'b1;
      bus.in_data  = words[0];
      for (int cyc = 0; cyc < 300 && ndone < 3; cyc++) begin
         will_accept = bus.in_valid && bus.in_ready;
         tick();
         if (will_accept) begin
            acc++;
            if (acc < 3) bus.in_data = words[acc];
            else begin bus.in_valid = 1'b0; bus.in_data = '0; end
         end
         bus.xfer_ack = req_prev;  // remote answers one cycle after seeing req
         if (bus.xfer_req && !req_prev) begin
            n_checks++;
            if (nreq >= 3) begin
               n_fail++; $display("FAIL b2b_extra_req: got %0d requests expected 3", nreq + 1);
            end else if (bus.xfer_data !== words[nreq]) begin
               n_fail++; $display("FAIL b2b_order req%0d: got %h expected %h", nreq, bus.xfer_data, words[nreq]);
            end
            held = bus.xfer_data;
            busy = 1'b1;
            nreq++;
         end else if (busy) begin
            n_checks++;
            if (bus.xfer_data !== held) begin n_fail++; $display("FAIL b2b_stable: got %h expected %h", bus.xfer_data, held); end
         end
         if (bus.xfer_done === 1'b1) begin
            busy = 1'b0;
            ndone++;
         end
         req_prev = bus.xfer_req;
      end
      bus.xfer_ack = 1'b0;
      n_checks++;
      if (ndone != 3) begin n_fail++; $display("FAIL b2b_done_count: got %0d expected 3", ndone); end
      n_checks++;
      if (nreq != 3) begin n_fail++; $display("FAIL b2b_req_count: got %0d expected 3", nreq); end
      n_checks++;
      if (acc != 3) begin n_fail++; $display("FAIL b2b_accept_count: got %0d expected 3", acc); end
   endtask

   task automatic test_ignored_input();
      bit ok;
      bus.in_valid = 1'b1;
      bus.in_data  = 32'hA5A50001;
      tick();
      for (int i = 0; i < 10; i++) begin
         bus.in_valid = 1'($urandom);
         bus.in_data  = $urandom;
         tick();
         n_checks++;
         if (bus.xfer_data !== 32'hA5A50001) begin n_fail++; $display("FAIL ignored_data cyc%0d: got %h expected a5a50001", i, bus.xfer_data); end
         n_checks++;
         if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL ignored_ready cyc%0d: got %b expected 0", i, bus.in_ready); end
      end
      bus.in_valid = 1'b0;
      n_checks++;
      if (bus.xfer_req !== 1'b1) begin n_fail++; $display("FAIL ignored_req_held: got %b expected 1", bus.xfer_req); end
      bus.xfer_ack = 1'b1;
      wait_req(1'b0, 10, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL ignored_req_fall: got no fall expected fall within 10 cycles"); end
      bus.xfer_ack = 1'b0;
      wait_done(10, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL ignored_done: got no pulse expected pulse within 10 cycles"); end
      n_checks++;
      if (bus.xfer_data !== 32'hA5A50001) begin n_fail++; $display("FAIL ignored_final_data: got %h expected a5a50001", bus.xfer_data); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h5555AAAA;
      tick();
      bus.in_valid = 1'b0;
      tick();
      n_checks++;
      if (bus.xfer_req !== 1'b1) begin n_fail++; $display("FAIL rstmid_req_up: got %b expected 1", bus.xfer_req); end
      bus.xfer_ack = 1'b1;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++;
      if (bus.xfer_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_req_drop: got %b expected 0", bus.xfer_req); end
      n_checks++;
      if (bus.xfer_data !== 32'h0) begin n_fail++; $display("FAIL rstmid_data_clr: got %h expected 00000000", bus.xfer_data); end
      tick();
      tick();  // stale ack is now through the synchronizer
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h12345678;
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready_ack_hi cyc%0d: got %b expected 0", i, bus.in_ready); end
         if (i < 4) tick();
      end
      n_checks++;
      if (bus.xfer_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_req: got %b expected 0", bus.xfer_req); end
      bus.xfer_ack = 1'b0;
      tick();
      n_checks++;
      if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready_1after: got %b expected 0", bus.in_ready); end
      n_checks++;
      if (bus.xfer_data !== 32'h0) begin n_fail++; $display("FAIL rstmid_no_capture: got %h expected 00000000", bus.xfer_data); end
      tick();
      n_checks++;
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready_2after: got %b expected 1", bus.in_ready); end
      tick();
      bus.in_valid = 1'b0;
      n_checks++;
      if (bus.xfer_data !== 32'h12345678) begin n_fail++; $display("FAIL rstmid_new_capture: got %h expected 12345678", bus.xfer_data); end
      wait_req(1'b1, 5, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL rstmid_new_req: got no req expected req within 5 cycles"); end
      bus.xfer_ack = 1'b1;
      wait_req(1'b0, 10, ok);
      bus.xfer_ack = 1'b0;
      wait_done(10, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL rstmid_new_done: got no pulse expected pulse within 10 cycles"); end
   endtask

   task automatic test_timeout();
      bit   ok;
      logic exp_err;
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h0BADF00D;
      tick();
      bus.in_valid = 1'b0;
      tick();  // edge entering REQ_HIGH
      n_checks++;
      if (bus.xfer_req !== 1'b1) begin n_fail++; $display("FAIL timeout_req_up: got %b expected 1", bus.xfer_req); end
      for (int k = 1; k <= 24; k++) begin
         tick();
         exp_err = TO_ON && (k >= 16);
         n_checks++;
         if (bus.timeout_err !== exp_err) begin
            n_fail++; $display("FAIL timeout_err edge%0d: got %b expected %b", k, bus.timeout_err, exp_err);
         end
      end
      n_checks++;
      if (bus.xfer_req !== 1'b1) begin n_fail++; $display("FAIL timeout_still_waiting: got %b expected 1", bus.xfer_req); end
      bus.xfer_ack = 1'b1;
      wait_req(1'b0, 10, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL timeout_late_ack: got no fall expected fall within 10 cycles"); end
      bus.xfer_ack = 1'b0;
      wait_done(10, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL timeout_done: got no pulse expected pulse within 10 cycles"); end
      n_checks++;
      if (bus.timeout_err !== TO_ON) begin n_fail++; $display("FAIL timeout_sticky: got %b expected %b", bus.timeout_err, TO_ON); end
      n_checks++;
      if (bus.xfer_data !== 32'h0BADF00D) begin n_fail++; $display("FAIL timeout_data: got %h expected 0badf00d", bus.xfer_data); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion expected finish before 200000 time units");
      $fatal(1, "bench watchdog expired");
   end

   initial begin
      clk      = 1'b0;
      rst      = 1'b1;
      n_checks = 0;
      n_fail   = 0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.xfer_ack = 1'b0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_ignored_input();
      test_reset_mid();
      test_timeout();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
